// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-word bit positions, fetch state and PC-control payload.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned CNT_W  = 8;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_LB    = 6'h20;
  localparam logic [OP_W-1:0] OP_SB    = 6'h28;

  // Control-word bit indices produced by the opcode decoder
  localparam int unsigned CW_PCW      = 0;
  localparam int unsigned CW_PCWC     = 1;
  localparam int unsigned CW_IORD     = 2;
  localparam int unsigned CW_MEMREAD  = 3;
  localparam int unsigned CW_MEMWRITE = 4;
  localparam int unsigned CW_IRWRITE  = 5;
  localparam int unsigned CW_MEMTOREG = 6;
  localparam int unsigned CW_REGDST   = 7;
  localparam int unsigned CW_REGWRITE = 8;
  localparam int unsigned CW_ALUSRCA  = 9;
  localparam int unsigned CW_ALUSRCB  = 10;
  localparam int unsigned CW_ALUOP    = 11;
  localparam int unsigned CW_PC_S     = 12;
  localparam int unsigned CW_MEMBYTE  = 13;
  localparam int unsigned CW_W        = 14;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_write_cond;
    logic branch_taken;
    logic flush;
  } pc_ctrl_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface inst_fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/inst_fetch_unit_pc_next_calc.sv
// Next-PC selection: flush > jump > taken branch > sequential.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [25:0]     instr_idx_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  pc_ctrl_t        ctrl_i,
  input  logic [XLEN-3:0] flush_word_i,
  output logic [XLEN-1:0] next_pc_c_o
);

  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] branch_tgt;

  assign jump_tgt   = {pc_plus4_i[XLEN-1 -: 4], instr_idx_i, 2'b00};
  assign branch_off = {{14{instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
  assign branch_tgt = pc_plus4_i + branch_off;

  always_comb begin
    next_pc_c_o = pc_plus4_i;
    if (ctrl_i.flush) begin
      next_pc_c_o = {flush_word_i, 2'b00};
    end else if (ctrl_i.pc_write) begin
      next_pc_c_o = jump_tgt;
    end else if (ctrl_i.pc_write_cond && ctrl_i.branch_taken) begin
      next_pc_c_o = branch_tgt;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: owns the PC, fetches over the imem handshake and holds the instruction register.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_fetch_unit_if.master   imem,
  output logic [XLEN-1:0]     ir_o,
  output logic [OP_W-1:0]     op_o,
  output logic                ir_valid,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     pc_plus4_o,
  input  logic                advance,
  input  logic                pc_write,
  input  logic                pc_write_cond,
  input  logic                branch_taken,
  input  logic                flush,
  input  logic [XLEN-1:0]     flush_pc,
  output logic                fetch_err
);

  localparam logic [XLEN-1:0] RESET_PC_A = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             waiting;
  logic [CNT_W:0]   cnt_inc;
  logic [XLEN-1:0]  next_pc_c;
  pc_ctrl_t         ctrl;

  assign ctrl = '{pc_write, pc_write_cond, branch_taken, flush};

  pc_next_calc u_pc_next_calc (
    .instr_idx_i  (ir_q[25:0]),
    .pc_plus4_i   (pc4_q),
    .ctrl_i       (ctrl),
    .flush_word_i (flush_pc[XLEN-1:2]),
    .next_pc_c_o  (next_pc_c)
  );

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC_A;
      pc4_q   <= RESET_PC_A + XLEN'(4);
      addr_q  <= RESET_PC_A;
      ir_q    <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Every new request restarts the ack timeout; imem_addr only moves when a request starts
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    waiting = 1'b0;

    case (state_q)
      FS_BOOT: begin
        state_d = FS_FETCH;
        cnt_d   = '0;
      end
      FS_FETCH: begin
        if (flush) begin
          pc_d  = next_pc_c;
          cnt_d = '0;
          if (imem.imem_ack) begin
            addr_d  = next_pc_c;
          end else begin
            state_d = FS_DRAIN;
          end
        end else if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = FS_HOLD;
        end else begin
          waiting = 1'b1;
        end
      end
      FS_HOLD: begin
        if (flush || advance) begin
          pc_d    = next_pc_c;
          addr_d  = next_pc_c;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = FS_FETCH;
        end
      end
      FS_DRAIN: begin
        if (imem.imem_ack) begin
          addr_d  = pc_q;
          cnt_d   = '0;
          state_d = FS_FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      default: state_d = FS_BOOT;
    endcase

    if (waiting) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_inc[CNT_W-1:0];
      if ((TIMEOUT != '0) && (cnt_inc == {1'b0, TIMEOUT})) begin
        err_d = 1'b1;
      end
    end

    pc4_d = pc_d + XLEN'(4);
    req_d = (state_d == FS_FETCH) || (state_d == FS_DRAIN);
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign ir_o           = ir_q;
  assign op_o           = ir_q[XLEN-1 -: OP_W];
  assign ir_valid       = valid_q;
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc4_q;
  assign fetch_err      = err_q;

endmodule
